fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
- Sequences the xfft_1 core between the audio sample source and downstream spectrum logic.
- Issues the configuration word after reset or on request, then frames the continuous audio samples into FFT_SIZE-point AXI-stream frames with tlast.
- Absorbs one sample of tready backpressure, and labels output bins with an index.
- Sits between the audio front end and the xfft_1 s_axis/m_axis ports.

Parameters:
- FFT_SIZE, 1024, points per frame (power of two, at least 8).
- SAMPLE_W, 16, audio sample width (signed).
- CFG_W, 16, config tdata width.
- CFG_WORD, 16'h0001, config word sent (bit0 = forward transform).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- audio_sample_in  in  SAMPLE_W  signed audio sample
- audio_valid_in  in  1  single-cycle sample strobe
- cfg_update_in  in  1  pulse requesting that the config word be re-sent
- s_axis_data_tdata  out  2*SAMPLE_W  {imag=0, real=sample}
- s_axis_data_tvalid  out  1
- s_axis_data_tlast  out  1
- s_axis_data_tready  in  1
- s_axis_config_tdata  out  CFG_W
- s_axis_config_tvalid  out  1
- s_axis_config_tready  in  1
- m_axis_data_tdata  in  2*SAMPLE_W  FFT output bin
- m_axis_data_tvalid  in  1
- m_axis_data_tlast  in  1
- m_axis_data_tready  out  1  (tied 1; the consumer must always accept)
- bin_data_out  out  2*SAMPLE_W  registered copy of the bin
- bin_index_out  out  $clog2(FFT_SIZE)  index of the bin
- bin_valid_out  out  1
- frame_err_out  out  1  sticky; framing error seen on the output side
- drop_count_out  out  16  dropped samples (statistics build only)
- frames_sent_out  out  16  frames fully sent (statistics build only)

Behaviour:
- Reset (asynchronous): all outputs 0, counters 0, holding register empty, state CFG.
- State CFG:
  - config_tvalid=1 with tdata=CFG_WORD, held until config_tready.
  - On the handshake, go to STREAM.
  - Data tvalid stays 0 in CFG.
- State STREAM:
  - A one-entry holding register drives the s_axis_data ports.
  - An audio_valid_in sample loads the register when it is empty, or when it is emptying this cycle (tvalid&&tready). In that case the load is same-cycle; there is no bubble.
  - Otherwise the sample is dropped and the drop counter increments, saturating at 16'hFFFF.
  - tvalid=1 while the register is full.
  - tlast=1 when the sample counter equals FFT_SIZE-1.
  - The sample counter increments on each tvalid&&tready handshake and wraps to 0 after FFT_SIZE-1. On that wrap, frames_sent increments (wrapping).
  - tdata is stable while tvalid&&!tready.
- Samples arriving in CFG are dropped and counted.
- cfg_update_in:
  - Latched into a pending flag.
  - Acted on only at a frame boundary: sample counter 0 and holding register empty. Then go to CFG.
  - A pulse in CFG, or while already pending, is ignored.
  - Frames are never cut short.
- Latency: sample strobe to tvalid is 1 cycle. FFT bin in to bin_valid_out is 1 cycle.
- Output side:
  - On m_axis tvalid: register the bin, assert bin_valid_out for 1 cycle, bin_index_out = output counter, then increment the counter.
  - If tlast arrives with counter != FFT_SIZE-1, or counter == FFT_SIZE-1 arrives without tlast: set frame_err_out (sticky until reset) and force the counter to 0.
  - The counter wraps to 0 after tlast.
- Simultaneous events:
  - A sample load and a handshake in the same cycle leave the register full with the new sample.
  - cfg_update_in in the same cycle as a frame completion switches to CFG on the next cycle if the register is then empty.

Optional Feature:
- Macro FFT_SEQ_STATS_EN.
- Defined: drop_count_out and frames_sent_out are live counters as described.
- Undefined: no counter flops; both ports are tied to 0. The drop and frame logic is otherwise unchanged.

Decomposition:
- Package fft_seq_pkg holds:
  - the state enum (CFG, STREAM)
  - SAMPLE_W and CFG_W defaults
  - a function packing a real sample into {16'h0, sample}.
- One sub-module, fft_bin_tracker: the output-side index counter, bin register and frame_err logic.

Test Plan:
- Config handshake: reset, with config_tready low for 5 cycles then high → config_tvalid high through the handshake with tdata=16'h0001; state reaches STREAM the next cycle, and data tvalid is 0 until then.
- Framing: FFT_SIZE=8, tready=1, samples 0..15 one per cycle → tlast on samples 7 and 15; frames_sent_out=2; drop_count_out=0.
- Backpressure: tready=0 for 3 cycles while a sample arrives each cycle → first sample held stable, next 2 dropped, drop_count_out=2; the held sample transfers when tready rises.
- Reconfig mid-frame: cfg_update_in pulsed at sample 3 of 8 → samples 4..7 still sent with tlast on 7; config_tvalid then asserts; samples arriving during CFG are counted as dropped.
- Output tracking: FFT model emits 8 bins with tlast on bin 7 → bin_index_out 0..7, frame_err_out=0. A further frame with tlast on bin 5 → frame_err_out=1 and the next bin has index 0.
- Async reset mid-frame at sample 4 → all outputs 0 immediately; CFG is re-entered and config is re-sent after release.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// ---------------------------------------------------------------------------
// fft_seq_pkg
// Shared types, default widths and helpers for the xfft_1 frame sequencer.
//   seq_state_e  : sequencer state (configuration word / sample streaming)
//   DEF_*        : default parameter values used by the sequencer modules
//   pack_real()  : builds a complex FFT input word {imag = 0, real = sample}
// ---------------------------------------------------------------------------
package fft_seq_pkg;

    localparam int              DEF_FFT_SIZE = 1024;
    localparam int              DEF_SAMPLE_W = 16;
    localparam int              DEF_CFG_W    = 16;
    // bit0 = 1 selects the forward transform
    localparam logic [15:0]     DEF_CFG_WORD = 16'h0001;

    typedef enum logic {
        ST_CFG    = 1'b0,
        ST_STREAM = 1'b1
    } seq_state_e;

    // The core takes {imag, real}; audio is purely real, so the upper half is zero.
    function automatic logic [2*DEF_SAMPLE_W-1:0] pack_real(input logic [DEF_SAMPLE_W-1:0] sample);
        return {{DEF_SAMPLE_W{1'b0}}, sample};
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer_if
// AXI-stream bundle between the sequencer and the xfft_1 core.
//   s_axis_data_*   : time-domain samples into the core
//   s_axis_config_* : configuration word into the core
//   m_axis_data_*   : frequency bins out of the core
// Modports:
//   master : sequencer side (drives s_axis_*, sinks m_axis_data)
//   slave  : FFT core side
// ---------------------------------------------------------------------------
interface fft_frame_sequencer_if
    import fft_seq_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int CFG_W    = DEF_CFG_W
) ();

    logic [2*SAMPLE_W-1:0] s_axis_data_tdata;
    logic                  s_axis_data_tvalid;
    logic                  s_axis_data_tlast;
    logic                  s_axis_data_tready;

    logic [CFG_W-1:0]      s_axis_config_tdata;
    logic                  s_axis_config_tvalid;
    logic                  s_axis_config_tready;

    logic [2*SAMPLE_W-1:0] m_axis_data_tdata;
    logic                  m_axis_data_tvalid;
    logic                  m_axis_data_tlast;
    logic                  m_axis_data_tready;

    modport master (
        output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
        input  s_axis_data_tready,
        output s_axis_config_tdata, s_axis_config_tvalid,
        input  s_axis_config_tready,
        input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        output m_axis_data_tready
    );

    modport slave (
        input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
        output s_axis_data_tready,
        input  s_axis_config_tdata, s_axis_config_tvalid,
        output s_axis_config_tready,
        output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
        input  m_axis_data_tready
    );

endinterface

// File: rtl/fft_bin_tracker.sv
// ---------------------------------------------------------------------------
// fft_bin_tracker
// Output side of the sequencer: registers each FFT bin, labels it with its
// index inside the frame and flags framing errors.
// Ports:
//   clk_in, rst_in   : clock, asynchronous active-high reset
//   bin_tdata_in     : bin from the core's m_axis_data
//   bin_tvalid_in    : bin strobe (consumer always ready)
//   bin_tlast_in     : last bin of the frame
//   bin_data_out     : registered bin
//   bin_index_out    : index of the registered bin
//   bin_valid_out    : one-cycle strobe, one cycle after the input bin
//   frame_err_out    : sticky, tlast and index disagreed at least once
// ---------------------------------------------------------------------------
module fft_bin_tracker
    import fft_seq_pkg::*;
#(
    parameter int  FFT_SIZE = DEF_FFT_SIZE,
    parameter int  DATA_W   = 2*DEF_SAMPLE_W,
    localparam int IDX_W    = $clog2(FFT_SIZE)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] bin_tdata_in,
    input  logic              bin_tvalid_in,
    input  logic              bin_tlast_in,
    output logic [DATA_W-1:0] bin_data_out,
    output logic [IDX_W-1:0]  bin_index_out,
    output logic              bin_valid_out,
    output logic              frame_err_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_SIZE - 1);

    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              valid_q, valid_d;
    logic              err_q,   err_d;

    always_comb begin
        // NOTE: every _d gets a default before any branch; a path that leaves one unassigned infers a latch.
        idx_d   = idx_q;
        data_d  = data_q;
        index_d = index_q;
        err_d   = err_q;
        valid_d = bin_tvalid_in;
        if (bin_tvalid_in) begin
            data_d  = bin_tdata_in;
            index_d = idx_q;
            // tlast must coincide exactly with the last index; any disagreement
            // resynchronises the counter to the start of a frame.
            if (bin_tlast_in != (idx_q == LAST_IDX)) begin
                err_d = 1'b1;
                idx_d = '0;
            end else if (bin_tlast_in) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: the bin register is reset only because it drives an output port; plain storage arrays are left unreset.
            idx_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            idx_q   <= idx_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bin_data_out  = data_q;
    assign bin_index_out = index_q;
    assign bin_valid_out = valid_q;
    assign frame_err_out = err_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
// Sequences the xfft_1 core: sends the configuration word after reset or on
// request, then frames the continuous audio samples into FFT_SIZE-point
// AXI-stream frames with tlast, and tracks the bins coming back.
// Ports:
//   clk_in, rst_in     : clock, asynchronous active-high reset
//   audio_sample_in    : signed audio sample
//   audio_valid_in     : single-cycle sample strobe
//   cfg_update_in      : pulse requesting the config word be re-sent
//   axis (master)      : s_axis_data, s_axis_config and m_axis_data to/from the core
//   bin_data_out       : registered copy of the last bin
//   bin_index_out      : index of that bin in its frame
//   bin_valid_out      : bin strobe
//   frame_err_out      : sticky output-side framing error
//   drop_count_out     : dropped samples, saturating   (statistics build only)
//   frames_sent_out    : frames fully sent, wrapping   (statistics build only)
// Build option:
//   FFT_SEQ_STATS_EN   : when defined, drop_count_out/frames_sent_out are live
//                        counters; otherwise both are tied to zero.
// ---------------------------------------------------------------------------
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int               FFT_SIZE = DEF_FFT_SIZE,
    parameter int               SAMPLE_W = DEF_SAMPLE_W,
    parameter int               CFG_W    = DEF_CFG_W,
    parameter logic [CFG_W-1:0] CFG_WORD = CFG_W'(DEF_CFG_WORD),
    localparam int              IDX_W    = $clog2(FFT_SIZE)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic signed [SAMPLE_W-1:0] audio_sample_in,
    input  logic                       audio_valid_in,
    input  logic                       cfg_update_in,
    fft_frame_sequencer_if.master      axis,
    output logic [2*SAMPLE_W-1:0]      bin_data_out,
    output logic [IDX_W-1:0]           bin_index_out,
    output logic                       bin_valid_out,
    output logic                       frame_err_out,
    output logic [15:0]                drop_count_out,
    output logic [15:0]                frames_sent_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_SIZE - 1);

    seq_state_e            state_q;
    logic                  cfg_valid_q;
    logic                  cfg_pend_q;

    logic                  full_q, full_d;
    logic [2*SAMPLE_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]      cnt_q,  cnt_d;

    logic                  in_stream;
    logic                  data_hs;
    logic                  at_last;
    logic                  at_boundary;
    logic                  go_cfg;
    logic                  load;

    assign in_stream   = (state_q == ST_STREAM);
    assign data_hs     = full_q && axis.s_axis_data_tready;
    assign at_last     = (cnt_q == LAST_IDX);
    // A reconfiguration may only start between frames with nothing in flight.
    assign at_boundary = (cnt_q == '0) && !full_q;
    assign go_cfg      = in_stream && at_boundary && (cfg_pend_q || cfg_update_in);
    // The register accepts a sample when empty or when it drains this cycle,
    // so back-to-back samples at full rate see no bubble. A sample arriving in
    // the very cycle the sequencer leaves for CFG is dropped like any CFG sample.
    assign load        = audio_valid_in && in_stream && !go_cfg && (!full_q || data_hs);

    // ---------------- holding register and sample counter ----------------
    always_comb begin
        full_d = full_q;
        hold_d = hold_q;
        cnt_d  = cnt_q;
        if (data_hs) begin
            full_d = 1'b0;
            cnt_d  = at_last ? '0 : cnt_q + 1'b1;
        end
        // Load after drain so a simultaneous load and handshake leave it full.
        if (load) begin
            full_d = 1'b1;
            hold_d = pack_real(audio_sample_in);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            full_q <= 1'b0;
            hold_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
        end
    end

    // ---------------- control FSM ----------------
    // cfg_valid_q rises one cycle after reset release so every output reads
    // zero while reset is held; later entries into CFG assert it directly.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_CFG;
            cfg_valid_q <= 1'b0;
            cfg_pend_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_CFG: begin
                    cfg_pend_q <= 1'b0;
                    if (cfg_valid_q && axis.s_axis_config_tready) begin
                        state_q     <= ST_STREAM;
                        cfg_valid_q <= 1'b0;
                    end else begin
                        cfg_valid_q <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (go_cfg) begin
                        state_q     <= ST_CFG;
                        cfg_valid_q <= 1'b1;
                        cfg_pend_q  <= 1'b0;
                    end else if (cfg_update_in) begin
                        cfg_pend_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign axis.s_axis_data_tdata    = hold_q;
    assign axis.s_axis_data_tvalid   = full_q;
    assign axis.s_axis_data_tlast    = full_q && at_last;
    assign axis.s_axis_config_tdata  = cfg_valid_q ? CFG_WORD : '0;
    assign axis.s_axis_config_tvalid = cfg_valid_q;
    assign axis.m_axis_data_tready   = 1'b1;

    // ---------------- output side ----------------
    fft_bin_tracker #(
        .FFT_SIZE (FFT_SIZE),
        .DATA_W   (2*SAMPLE_W)
    ) u_bin_tracker (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .bin_tdata_in  (axis.m_axis_data_tdata),
        .bin_tvalid_in (axis.m_axis_data_tvalid),
        .bin_tlast_in  (axis.m_axis_data_tlast),
        .bin_data_out  (bin_data_out),
        .bin_index_out (bin_index_out),
        .bin_valid_out (bin_valid_out),
        .frame_err_out (frame_err_out)
    );

    // ---------------- statistics ----------------
`ifdef FFT_SEQ_STATS_EN
    logic        drop;
    logic        frame_done;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] frames_q,   frames_d;

    assign drop       = audio_valid_in && !load;
    assign frame_done = data_hs && at_last;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        frames_d   = frames_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (frame_done) begin
            frames_d = frames_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            drop_cnt_q <= '0;
            frames_q   <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            frames_q   <= frames_d;
        end
    end

    assign drop_count_out  = drop_cnt_q;
    assign frames_sent_out = frames_q;
`else
    assign drop_count_out  = '0;
    assign frames_sent_out = '0;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sequencer
// Self-checking bench for fft_frame_sequencer with FFT_SIZE = 8. Expected
// samples and bins are queued as stimulus is driven and compared by a
// negedge monitor when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_fft_frame_sequencer;

    localparam int FFT_SIZE = 8;
    localparam int SAMPLE_W = 16;
    localparam int CFG_W    = 16;
    localparam int IDX_W    = 3;

`ifdef FFT_SEQ_STATS_EN
    localparam logic [15:0] STAT_MASK = 16'hFFFF;
`else
    localparam logic [15:0] STAT_MASK = 16'h0000;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } smp_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [IDX_W-1:0] idx;
    } bin_t;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] audio_sample;
    logic               audio_valid;
    logic               cfg_update;
    logic [31:0]        bin_data;
    logic [IDX_W-1:0]   bin_index;
    logic               bin_valid;
    logic               frame_err;
    logic [15:0]        drop_count;
    logic [15:0]        frames_sent;

    smp_t smp_q[$];
    bin_t bin_q[$];
    smp_t smp_e;
    bin_t bin_e;

    int checks     = 0;
    int errors     = 0;
    int exp_drop   = 0;
    int exp_frames = 0;
    int exp_pos    = 0;

    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.SAMPLE_W(SAMPLE_W), .CFG_W(CFG_W)) axis ();

    fft_frame_sequencer #(
        .FFT_SIZE (FFT_SIZE),
        .SAMPLE_W (SAMPLE_W),
        .CFG_W    (CFG_W),
        .CFG_WORD (16'h0001)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .audio_sample_in (audio_sample),
        .audio_valid_in  (audio_valid),
        .cfg_update_in   (cfg_update),
        .axis            (axis),
        .bin_data_out    (bin_data),
        .bin_index_out   (bin_index),
        .bin_valid_out   (bin_valid),
        .frame_err_out   (frame_err),
        .drop_count_out  (drop_count),
        .frames_sent_out (frames_sent)
    );

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && axis.s_axis_data_tvalid && axis.s_axis_data_tready) begin
            checks++;
            if (smp_q.size() == 0) begin
                errors++;
                $display("FAIL sample_unexpected: got tdata=%h tlast=%b, expected no transfer",
                         axis.s_axis_data_tdata, axis.s_axis_data_tlast);
            end else begin
                smp_e = smp_q.pop_front();
                if ({axis.s_axis_data_tdata, axis.s_axis_data_tlast} !== {smp_e.data, smp_e.last}) begin
                    errors++;
                    $display("FAIL sample_transfer: got tdata=%h tlast=%b, expected tdata=%h tlast=%b",
                             axis.s_axis_data_tdata, axis.s_axis_data_tlast, smp_e.data, smp_e.last);
                end
            end
        end
        if (!rst && bin_valid) begin
            checks++;
            if (bin_q.size() == 0) begin
                errors++;
                $display("FAIL bin_unexpected: got data=%h index=%0d, expected no bin", bin_data, bin_index);
            end else begin
                bin_e = bin_q.pop_front();
                if ({bin_data, bin_index} !== {bin_e.data, bin_e.idx}) begin
                    errors++;
                    $display("FAIL bin_output: got data=%h index=%0d, expected data=%h index=%0d",
                             bin_data, bin_index, bin_e.data, bin_e.idx);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue a sample the bench expects the DUT to accept, tracking frame position.
    task automatic push_exp(input logic [15:0] s);
        smp_q.push_back('{data: {16'h0000, s}, last: (exp_pos == FFT_SIZE - 1)});
        if (exp_pos == FFT_SIZE - 1) begin
            exp_pos = 0;
            exp_frames++;
        end else begin
            exp_pos++;
        end
    endtask

    task automatic idle_inputs();
        audio_sample                = '0;
        audio_valid                 = 1'b0;
        cfg_update                  = 1'b0;
        axis.s_axis_data_tready     = 1'b0;
        axis.s_axis_config_tready   = 1'b0;
        axis.m_axis_data_tdata      = '0;
        axis.m_axis_data_tvalid     = 1'b0;
        axis.m_axis_data_tlast      = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [119:0] obs;
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        obs = {axis.s_axis_data_tvalid, axis.s_axis_data_tlast, axis.s_axis_data_tdata,
               axis.s_axis_config_tvalid, axis.s_axis_config_tdata, bin_data, bin_index,
               bin_valid, frame_err, drop_count, frames_sent};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected all zero", obs);
        end
        checks++;
        if (axis.m_axis_data_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_m_tready: got %b, expected 1", axis.m_axis_data_tready);
        end
        rst        = 1'b0;
        exp_drop   = 0;
        exp_frames = 0;
        exp_pos    = 0;
    endtask

    task automatic test_config();
        axis.s_axis_config_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            audio_valid  = (k == 2);
            audio_sample = 16'sd77;
            if (k == 2) exp_drop++;
            tick();
            checks++;
            if ({axis.s_axis_config_tvalid, axis.s_axis_config_tdata, axis.s_axis_data_tvalid} !== {1'b1, 16'h0001, 1'b0}) begin
                errors++;
                $display("FAIL cfg_wait[%0d]: got cfg_tvalid=%b cfg_tdata=%h data_tvalid=%b, expected 1 0001 0",
                         k, axis.s_axis_config_tvalid, axis.s_axis_config_tdata, axis.s_axis_data_tvalid);
            end
        end
        audio_valid = 1'b0;
        axis.s_axis_config_tready = 1'b1;
        tick();
        axis.s_axis_config_tready = 1'b0;
        checks++;
        if ({axis.s_axis_config_tvalid, axis.s_axis_data_tvalid} !== 2'b00) begin
            errors++;
            $display("FAIL cfg_done: got cfg_tvalid=%b data_tvalid=%b, expected 0 0",
                     axis.s_axis_config_tvalid, axis.s_axis_data_tvalid);
        end
        checks++;
        if (drop_count !== (16'(exp_drop) & STAT_MASK)) begin
            errors++;
            $display("FAIL cfg_drop: got %0d, expected %0d", drop_count, 16'(exp_drop) & STAT_MASK);
        end
    endtask

    task automatic test_framing();
        logic [15:0] s;
        axis.s_axis_data_tready = 1'b1;
        for (int i = 0; i < 2 * FFT_SIZE; i++) begin
            s            = 16'(i * 37 - 200);
            audio_valid  = 1'b1;
            audio_sample = s;
            push_exp(s);
            tick();
            if (i == 0) begin
                checks++;
                if ({axis.s_axis_data_tvalid, axis.s_axis_data_tdata} !== {1'b1, 16'h0000, s}) begin
                    errors++;
                    $display("FAIL frame_latency: got tvalid=%b tdata=%h, expected 1 %h",
                             axis.s_axis_data_tvalid, axis.s_axis_data_tdata, {16'h0000, s});
                end
            end
        end
        audio_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if ({axis.s_axis_data_tvalid, 32'(smp_q.size())} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL frame_drain: got tvalid=%b pending=%0d, expected 0 0",
                     axis.s_axis_data_tvalid, smp_q.size());
        end
        checks++;
        if ({frames_sent, drop_count} !== {16'(exp_frames) & STAT_MASK, 16'(exp_drop) & STAT_MASK}) begin
            errors++;
            $display("FAIL frame_stats: got frames=%0d drops=%0d, expected frames=%0d drops=%0d",
                     frames_sent, drop_count, 16'(exp_frames) & STAT_MASK, 16'(exp_drop) & STAT_MASK);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a;
        a = 16'hFB2E;
        axis.s_axis_data_tready = 1'b0;
        audio_valid  = 1'b1;
        audio_sample = a;
        push_exp(a);
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({axis.s_axis_data_tvalid, axis.s_axis_data_tdata} !== {1'b1, 16'h0000, a}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got tvalid=%b tdata=%h, expected 1 %h",
                         k, axis.s_axis_data_tvalid, axis.s_axis_data_tdata, {16'h0000, a});
            end
            if (k < 2) begin
                audio_sample = 16'(1000 + k);
                exp_drop++;
                tick();
            end
        end
        audio_valid = 1'b0;
        checks++;
        if (drop_count !== (16'(exp_drop) & STAT_MASK)) begin
            errors++;
            $display("FAIL bp_drop: got %0d, expected %0d", drop_count, 16'(exp_drop) & STAT_MASK);
        end
        axis.s_axis_data_tready = 1'b1;
        tick();
        checks++;
        if ({axis.s_axis_data_tvalid, 32'(smp_q.size())} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL bp_release: got tvalid=%b pending=%0d, expected 0 0",
                     axis.s_axis_data_tvalid, smp_q.size());
        end
        // Finish the frame so later tests start on a boundary.
        for (int i = 0; i < FFT_SIZE - 1; i++) begin
            audio_valid  = 1'b1;
            audio_sample = 16'(300 + i);
            push_exp(16'(300 + i));
            tick();
        end
        audio_valid = 1'b0;
        tick();
    endtask

    task automatic test_reconfig();
        int waited;
        axis.s_axis_data_tready = 1'b1;
        for (int i = 0; i < FFT_SIZE; i++) begin
            audio_valid  = 1'b1;
            audio_sample = 16'(-i * 11);
            cfg_update   = (i == 3);
            push_exp(16'(-i * 11));
            tick();
        end
        audio_valid = 1'b0;
        cfg_update  = 1'b0;
        waited = 0;
        while (!axis.s_axis_config_tvalid && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if (axis.s_axis_config_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL reconfig_timeout: got cfg_tvalid=%b after %0d cycles, expected 1",
                     axis.s_axis_config_tvalid, waited);
        end
        checks++;
        if ({axis.s_axis_data_tvalid, 32'(smp_q.size())} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reconfig_frame_complete: got tvalid=%b pending=%0d, expected 0 0",
                     axis.s_axis_data_tvalid, smp_q.size());
        end
        // Samples arriving while the config word waits are dropped.
        audio_valid  = 1'b1;
        audio_sample = 16'sd55;
        exp_drop += 2;
        repeat (2) tick();
        audio_valid = 1'b0;
        checks++;
        if ({axis.s_axis_data_tvalid, drop_count, frames_sent} !==
            {1'b0, 16'(exp_drop) & STAT_MASK, 16'(exp_frames) & STAT_MASK}) begin
            errors++;
            $display("FAIL reconfig_cfg_drop: got tvalid=%b drops=%0d frames=%0d, expected 0 %0d %0d",
                     axis.s_axis_data_tvalid, drop_count, frames_sent,
                     16'(exp_drop) & STAT_MASK, 16'(exp_frames) & STAT_MASK);
        end
        axis.s_axis_config_tready = 1'b1;
        tick();
        axis.s_axis_config_tready = 1'b0;
        // Streaming resumes and the request does not fire a second time.
        audio_valid  = 1'b1;
        audio_sample = 16'sd4321;
        push_exp(16'sd4321);
        tick();
        audio_valid = 1'b0;
        checks++;
        if ({axis.s_axis_config_tvalid, axis.s_axis_data_tvalid} !== 2'b01) begin
            errors++;
            $display("FAIL reconfig_resume: got cfg_tvalid=%b data_tvalid=%b, expected 0 1",
                     axis.s_axis_config_tvalid, axis.s_axis_data_tvalid);
        end
        tick();
    endtask

    task automatic test_bins();
        logic [31:0] d;
        for (int i = 0; i < FFT_SIZE; i++) begin
            d = $urandom;
            axis.m_axis_data_tdata  = d;
            axis.m_axis_data_tvalid = 1'b1;
            axis.m_axis_data_tlast  = (i == FFT_SIZE - 1);
            bin_q.push_back('{data: d, idx: IDX_W'(i)});
            tick();
            if (i == 0) begin
                checks++;
                if (bin_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bin_latency: got bin_valid=%b, expected 1", bin_valid);
                end
            end
        end
        axis.m_axis_data_tvalid = 1'b0;
        axis.m_axis_data_tlast  = 1'b0;
        tick();
        checks++;
        if ({frame_err, bin_valid, 32'(bin_q.size())} !== {2'b00, 32'd0}) begin
            errors++;
            $display("FAIL bin_good_frame: got err=%b valid=%b pending=%0d, expected 0 0 0",
                     frame_err, bin_valid, bin_q.size());
        end
        // Short frame: tlast on bin 5.
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            axis.m_axis_data_tdata  = d;
            axis.m_axis_data_tvalid = 1'b1;
            axis.m_axis_data_tlast  = (i == 5);
            bin_q.push_back('{data: d, idx: IDX_W'(i)});
            tick();
        end
        axis.m_axis_data_tvalid = 1'b0;
        axis.m_axis_data_tlast  = 1'b0;
        tick();
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL bin_short_err: got %b, expected 1", frame_err);
        end
        d = 32'h1234_ABCD;
        axis.m_axis_data_tdata  = d;
        axis.m_axis_data_tvalid = 1'b1;
        bin_q.push_back('{data: d, idx: '0});
        tick();
        axis.m_axis_data_tvalid = 1'b0;
        tick();
        checks++;
        if ({frame_err, 32'(bin_q.size())} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL bin_after_err: got err=%b pending=%0d, expected 1 0", frame_err, bin_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic [119:0] obs;
        int waited;
        axis.s_axis_data_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            audio_valid  = 1'b1;
            audio_sample = 16'(50 + i);
            if (i < 4) push_exp(16'(50 + i));
            tick();
        end
        audio_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        obs = {axis.s_axis_data_tvalid, axis.s_axis_data_tlast, axis.s_axis_data_tdata,
               axis.s_axis_config_tvalid, axis.s_axis_config_tdata, bin_data, bin_index,
               bin_valid, frame_err, drop_count, frames_sent};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h, expected all zero", obs);
        end
        checks++;
        if (smp_q.size() != 0) begin
            errors++;
            $display("FAIL async_reset_sent: got pending=%0d, expected 0", smp_q.size());
        end
        tick();
        rst        = 1'b0;
        exp_drop   = 0;
        exp_frames = 0;
        exp_pos    = 0;
        waited = 0;
        while (!axis.s_axis_config_tvalid && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if ({axis.s_axis_config_tvalid, axis.s_axis_config_tdata} !== {1'b1, 16'h0001}) begin
            errors++;
            $display("FAIL async_reset_cfg: got cfg_tvalid=%b tdata=%h, expected 1 0001",
                     axis.s_axis_config_tvalid, axis.s_axis_config_tdata);
        end
        axis.s_axis_config_tready = 1'b1;
        tick();
        axis.s_axis_config_tready = 1'b0;
        for (int i = 0; i < FFT_SIZE; i++) begin
            audio_valid  = 1'b1;
            audio_sample = 16'(700 - i);
            push_exp(16'(700 - i));
            tick();
        end
        audio_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if ({32'(smp_q.size()), frames_sent, drop_count} !==
            {32'd0, 16'(exp_frames) & STAT_MASK, 16'(exp_drop) & STAT_MASK}) begin
            errors++;
            $display("FAIL async_reset_restream: got pending=%0d frames=%0d drops=%0d, expected 0 %0d %0d",
                     smp_q.size(), frames_sent, drop_count,
                     16'(exp_frames) & STAT_MASK, 16'(exp_drop) & STAT_MASK);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_framing();
        test_backpressure();
        test_reconfig();
        test_bins();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
